// File: rtl/anc_pwm_out_if.sv
// Sample bus from the adaptive FIR stage into the ANC PWM output stage.
// The master drives a one-cycle ready strobe that qualifies both samples.
interface anc_pwm_out_if;
  logic               ready_in;
  logic signed [15:0] anti_in;
  logic signed [15:0] audio_in;

  modport master (output ready_in, output anti_in, output audio_in);
  modport slave  (input  ready_in, input  anti_in, input  audio_in);
endinterface

// File: rtl/anc_pwm_out.sv
// ANC output stage: saturating mix of anti-noise and playback audio, mute/gain,
// double-buffered PWM duty, sticky clip/overrun flags. Optional soft-mute ramp: ANC_SOFT_MUTE_EN.
module anc_pwm_out #(
  parameter int PWM_BITS   = 8,
  parameter int GAIN_UNITY = 128
) (
  input  logic         clk_in,
  input  logic         rst_in,
  anc_pwm_out_if.slave smp,
  input  logic         mute_in,
  input  logic         clear_in,
  output logic         pwm_out,
  output logic         clip_out,
  output logic         overrun_out
);

  localparam int GAIN_W     = $clog2(GAIN_UNITY + 1);
  localparam int GAIN_SHIFT = 7;
  localparam int PROD_W     = 17 + GAIN_W;

  localparam logic [PWM_BITS-1:0] DUTY_MID  = {1'b1, {(PWM_BITS-1){1'b0}}};
  localparam logic [PWM_BITS-1:0] CNT_MAX   = {PWM_BITS{1'b1}};
  localparam logic [GAIN_W-1:0]   GAIN_FULL = GAIN_W'(GAIN_UNITY);

  logic [GAIN_W-1:0] gain_eff;

  // ---------------- S1: saturating mix ----------------
  logic signed [16:0] mix;
  logic               mix_ovf;
  logic signed [15:0] mix_sat;

  always_comb begin
    mix     = {smp.audio_in[15], smp.audio_in} + {smp.anti_in[15], smp.anti_in};
    mix_ovf = mix[16] ^ mix[15];
    mix_sat = mix[15:0];
    if (mix_ovf) begin
      mix_sat = mix[16] ? 16'sh8000 : 16'sh7fff;
    end
  end

  logic               s1_valid_q, s1_valid_d;
  logic signed [15:0] s1_sat_q,   s1_sat_d;

  // ---------------- Gain source ----------------
`ifdef ANC_SOFT_MUTE_EN
  typedef enum logic [1:0] {
    ST_MUTED,
    ST_RAMP_UP,
    ST_ACTIVE,
    ST_RAMP_DOWN
  } mute_state_e;

  mute_state_e       state_q, state_d;
  logic [GAIN_W-1:0] gain_q,  gain_d;

  always_comb begin
    state_d = state_q;
    gain_d  = gain_q;
    case (state_q)
      ST_MUTED: begin
        if (!mute_in) state_d = ST_RAMP_UP;
      end
      ST_RAMP_UP: begin
        if (mute_in) begin
          state_d = ST_RAMP_DOWN;
        end else if (gain_q == GAIN_FULL) begin
          state_d = ST_ACTIVE;
        end else if (smp.ready_in) begin
          gain_d = gain_q + GAIN_W'(1);
          if (gain_d == GAIN_FULL) state_d = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        if (mute_in) state_d = ST_RAMP_DOWN;
      end
      ST_RAMP_DOWN: begin
        // A quick mute toggle can land here at gain 0; never wrap below zero.
        if (!mute_in) begin
          state_d = ST_RAMP_UP;
        end else if (gain_q == '0) begin
          state_d = ST_MUTED;
        end else if (smp.ready_in) begin
          gain_d = gain_q - GAIN_W'(1);
          if (gain_d == '0) state_d = ST_MUTED;
        end
      end
      default: begin
        state_d = ST_MUTED;
        gain_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= ST_MUTED;
      gain_q  <= '0;
    end else begin
      state_q <= state_d;
      gain_q  <= gain_d;
    end
  end

  assign gain_eff = gain_q;
`else
  assign gain_eff = mute_in ? '0 : GAIN_FULL;
`endif

  // ---------------- S2: gain scaling ----------------
  logic signed [PROD_W-1:0] prod;
  logic                     s2_valid_q, s2_valid_d;
  logic signed [15:0]       s2_scaled_q, s2_scaled_d;

  always_comb begin
    prod        = PROD_W'(s1_sat_q) * $signed(PROD_W'(gain_eff));
    s2_valid_d  = s1_valid_q;
    s2_scaled_d = s1_valid_q ? 16'(prod >>> GAIN_SHIFT) : s2_scaled_q;
  end

  // ---------------- S3 + PWM ----------------
  logic [15:0]         offset_bin;
  logic [PWM_BITS-1:0] duty_new;
  logic [PWM_BITS-1:0] cnt_q, cnt_d;
  logic [PWM_BITS-1:0] active_q, active_d;
  logic [PWM_BITS-1:0] pend_q, pend_d;
  logic                pend_valid_q, pend_valid_d;
  logic                pwm_q, pwm_d;
  logic                clip_q, clip_d;
  logic                overrun_q, overrun_d;
  logic                wrap_load;
  logic                overrun_evt;
  logic                clip_evt;

  always_comb begin
    s1_valid_d = smp.ready_in;
    s1_sat_d   = smp.ready_in ? mix_sat : s1_sat_q;

    // Signed to offset-binary, then keep the top PWM_BITS as the duty code.
    offset_bin = s2_scaled_q ^ 16'h8000;
    duty_new   = PWM_BITS'(offset_bin >> (16 - PWM_BITS));

    cnt_d     = cnt_q + PWM_BITS'(1);
    pwm_d     = (cnt_q < active_q);
    wrap_load = (cnt_q == CNT_MAX) && pend_valid_q;
    active_d  = wrap_load ? pend_q : active_q;

    // A write coinciding with the wrap load keeps the new value pending, no overrun.
    pend_d       = s2_valid_q ? duty_new : pend_q;
    pend_valid_d = s2_valid_q | (pend_valid_q & ~wrap_load);
    overrun_evt  = s2_valid_q & pend_valid_q & ~wrap_load;
    clip_evt     = smp.ready_in & mix_ovf;

    clip_d    = (clip_q & ~clear_in) | clip_evt;
    overrun_d = (overrun_q & ~clear_in) | overrun_evt;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      s1_valid_q   <= 1'b0;
      s1_sat_q     <= '0;
      s2_valid_q   <= 1'b0;
      s2_scaled_q  <= '0;
      cnt_q        <= '0;
      active_q     <= DUTY_MID;
      pend_q       <= DUTY_MID;
      pend_valid_q <= 1'b0;
      pwm_q        <= 1'b0;
      clip_q       <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_sat_q     <= s1_sat_d;
      s2_valid_q   <= s2_valid_d;
      s2_scaled_q  <= s2_scaled_d;
      cnt_q        <= cnt_d;
      active_q     <= active_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      pwm_q        <= pwm_d;
      clip_q       <= clip_d;
      overrun_q    <= overrun_d;
    end
  end

  assign pwm_out     = pwm_q;
  assign clip_out    = clip_q;
  assign overrun_out = overrun_q;

endmodule
